// File: rtl/pc_unit.sv
// 6502-style program counter: reset-vector fetch, increment, load and relative branch with page-cross fix-up.
// Optional `PC_WATCH_EN adds a registered address-watch comparator (watch_addr / watch_hit).
//
// state  | meaning
// VEC_LO | requesting reset vector low byte at RESET_VECTOR
// VEC_HI | requesting reset vector high byte at RESET_VECTOR+1
// RUN    | PC valid, inc/load/branch accepted
// BR_FIX | cross-page branch: low byte updated, high byte fixed this cycle
module pc_unit #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  inc,
    input  logic                  load,
    input  logic                  branch,
`ifdef PC_WATCH_EN
    input  logic [ADDR_WIDTH-1:0] watch_addr,
    output logic                  watch_hit,
`endif
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] vec_addr,
    output logic                  vec_req,
    output logic                  ready,
    output logic                  page_cross
);

    localparam int HI_W = ADDR_WIDTH - DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] VEC_HI_ADDR = RESET_VECTOR + 1'b1;

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2,
        BR_FIX = 2'd3
    } state_t;

    state_t                state;
    logic [HI_W-1:0]       hi_latch;
    logic [ADDR_WIDTH-1:0] offset_ext;
    logic [ADDR_WIDTH-1:0] br_tgt;

    always_comb begin
        offset_ext = {{HI_W{data_in[DATA_WIDTH-1]}}, data_in};
        br_tgt     = pc_out + offset_ext;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= VEC_LO;
            pc_out     <= '0;
            vec_req    <= 1'b1;
            vec_addr   <= RESET_VECTOR;
            ready      <= 1'b0;
            page_cross <= 1'b0;
            hi_latch   <= '0;
        end else begin
            page_cross <= 1'b0;
            case (state)
                VEC_LO: begin
                    if (data_valid) begin
                        pc_out[DATA_WIDTH-1:0] <= data_in;
                        vec_addr               <= VEC_HI_ADDR;
                        state                  <= VEC_HI;
                    end
                end
                VEC_HI: begin
                    if (data_valid) begin
                        pc_out[ADDR_WIDTH-1:DATA_WIDTH] <= data_in;
                        vec_req                         <= 1'b0;
                        ready                           <= 1'b1;
                        state                           <= RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        pc_out <= addr_in;
                    end else if (branch) begin
                        if (br_tgt[ADDR_WIDTH-1:DATA_WIDTH] == pc_out[ADDR_WIDTH-1:DATA_WIDTH]) begin
                            pc_out <= br_tgt;
                        end else begin
                            // pc_out shows {old_hi,new_lo} for one cycle, as the 6502 dummy read does
                            pc_out[DATA_WIDTH-1:0] <= br_tgt[DATA_WIDTH-1:0];
                            hi_latch               <= br_tgt[ADDR_WIDTH-1:DATA_WIDTH];
                            ready                  <= 1'b0;
                            state                  <= BR_FIX;
                        end
                    end else if (inc) begin
                        pc_out <= pc_out + 1'b1;
                    end
                end
                BR_FIX: begin
                    pc_out[ADDR_WIDTH-1:DATA_WIDTH] <= hi_latch;
                    ready                           <= 1'b1;
                    page_cross                      <= 1'b1;
                    state                           <= RUN;
                end
                default: state <= VEC_LO;
            endcase
        end
    end

`ifdef PC_WATCH_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            watch_hit <= 1'b0;
        end else begin
            watch_hit <= (state == RUN) && (pc_out == watch_addr);
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; exercises the watch port only when PC_WATCH_EN is defined.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  data_in;
    logic        data_valid;
    logic [15:0] addr_in;
    logic        inc, load, branch;
    logic [15:0] pc_out, vec_addr;
    logic        vec_req, ready, page_cross;
`ifdef PC_WATCH_EN
    logic [15:0] watch_addr;
    logic        watch_hit;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .addr_in    (addr_in),
        .inc        (inc),
        .load       (load),
        .branch     (branch),
`ifdef PC_WATCH_EN
        .watch_addr (watch_addr),
        .watch_hit  (watch_hit),
`endif
        .pc_out     (pc_out),
        .vec_addr   (vec_addr),
        .vec_req    (vec_req),
        .ready      (ready),
        .page_cross (page_cross)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic boot(input logic [7:0] lo, input logic [7:0] hi);
        reset_n = 1'b0; tick();
        reset_n = 1'b1;
        data_valid = 1'b1; data_in = lo; tick();
        data_in = hi; tick();
        data_valid = 1'b0; data_in = 8'h00;
    endtask

    task automatic set_pc(input logic [15:0] v);
        load = 1'b1; addr_in = v; tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick();
        n_checks++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h exp 0000", pc_out); end
        n_checks++; if (vec_addr !== 16'hFFFC) begin n_fail++; $display("FAIL reset_vec_addr got %h exp FFFC", vec_addr); end
        n_checks++; if ({vec_req, ready, page_cross} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got %b exp 100", {vec_req, ready, page_cross}); end
        reset_n = 1'b1;
    endtask

    task automatic test_vector_stall();
        // commands while fetching the vector must be ignored
        inc = 1'b1; load = 1'b1; branch = 1'b1; addr_in = 16'h5555; data_in = 8'h77;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if ({vec_addr, pc_out, vec_req, ready} !== {16'hFFFC, 16'h0000, 2'b10}) begin
                n_fail++; $display("FAIL stall_%0d got addr %h pc %h req %b rdy %b exp FFFC 0000 1 0", i, vec_addr, pc_out, vec_req, ready);
            end
        end
        inc = 1'b0; load = 1'b0; branch = 1'b0;
        data_valid = 1'b1; data_in = 8'h34; tick();
        n_checks++; if ({vec_addr, pc_out, vec_req, ready} !== {16'hFFFD, 16'h0034, 2'b10}) begin
            n_fail++; $display("FAIL vec_lo got addr %h pc %h req %b rdy %b exp FFFD 0034 1 0", vec_addr, pc_out, vec_req, ready);
        end
        data_valid = 1'b0; tick();
        n_checks++; if ({vec_addr, pc_out, ready} !== {16'hFFFD, 16'h0034, 1'b0}) begin
            n_fail++; $display("FAIL vec_hi_hold got addr %h pc %h rdy %b exp FFFD 0034 0", vec_addr, pc_out, ready);
        end
        data_valid = 1'b1; data_in = 8'h12; tick();
        n_checks++; if ({pc_out, vec_req, ready} !== {16'h1234, 2'b01}) begin
            n_fail++; $display("FAIL vec_done got pc %h req %b rdy %b exp 1234 0 1", pc_out, vec_req, ready);
        end
        data_in = 8'h99; tick();
        n_checks++; if (pc_out !== 16'h1234) begin n_fail++; $display("FAIL run_ignores_valid got %h exp 1234", pc_out); end
        data_valid = 1'b0;
    endtask

    task automatic test_branch_same_page();
        set_pc(16'h10F0);
        branch = 1'b1; data_in = 8'h05; tick(); branch = 1'b0;
        n_checks++; if ({pc_out, ready, page_cross} !== {16'h10F5, 2'b10}) begin
            n_fail++; $display("FAIL br_fwd got pc %h rdy %b pcx %b exp 10F5 1 0", pc_out, ready, page_cross);
        end
        set_pc(16'h10F0);
        branch = 1'b1; data_in = 8'h80; tick(); branch = 1'b0;
        n_checks++; if ({pc_out, page_cross} !== {16'h1070, 1'b0}) begin
            n_fail++; $display("FAIL br_back got pc %h pcx %b exp 1070 0", pc_out, page_cross);
        end
    endtask

    task automatic test_page_cross();
        set_pc(16'h10F0);
        branch = 1'b1; data_in = 8'h20; tick(); branch = 1'b0;
        n_checks++; if ({pc_out, ready, page_cross} !== {16'h1010, 2'b00}) begin
            n_fail++; $display("FAIL pcx_fwd_dummy got pc %h rdy %b pcx %b exp 1010 0 0", pc_out, ready, page_cross);
        end
        inc = 1'b1; load = 1'b1; addr_in = 16'hDEAD; tick(); inc = 1'b0; load = 1'b0;
        n_checks++; if ({pc_out, ready, page_cross} !== {16'h1110, 2'b11}) begin
            n_fail++; $display("FAIL pcx_fwd_fix got pc %h rdy %b pcx %b exp 1110 1 1", pc_out, ready, page_cross);
        end
        tick();
        n_checks++; if ({pc_out, page_cross} !== {16'h1110, 1'b0}) begin
            n_fail++; $display("FAIL pcx_pulse_end got pc %h pcx %b exp 1110 0", pc_out, page_cross);
        end
        set_pc(16'h1005);
        branch = 1'b1; data_in = 8'hF0; tick(); branch = 1'b0;
        n_checks++; if ({pc_out, ready} !== {16'h10F5, 1'b0}) begin
            n_fail++; $display("FAIL pcx_back_dummy got pc %h rdy %b exp 10F5 0", pc_out, ready);
        end
        tick();
        n_checks++; if ({pc_out, page_cross} !== {16'h0FF5, 1'b1}) begin
            n_fail++; $display("FAIL pcx_back_fix got pc %h pcx %b exp 0FF5 1", pc_out, page_cross);
        end
        set_pc(16'hFFF0);
        branch = 1'b1; data_in = 8'h20; tick(); branch = 1'b0;
        n_checks++; if (pc_out !== 16'hFF10) begin n_fail++; $display("FAIL pcx_wrap_dummy got %h exp FF10", pc_out); end
        tick();
        n_checks++; if ({pc_out, page_cross} !== {16'h0010, 1'b1}) begin
            n_fail++; $display("FAIL pcx_wrap_fix got pc %h pcx %b exp 0010 1", pc_out, page_cross);
        end
    endtask

    task automatic test_inc_priority();
        set_pc(16'hFFFF);
        inc = 1'b1; tick(); inc = 1'b0;
        n_checks++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap got %h exp 0000", pc_out); end
        tick();
        n_checks++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL idle_hold got %h exp 0000", pc_out); end
        load = 1'b1; branch = 1'b1; inc = 1'b1; addr_in = 16'hABCD; data_in = 8'h05; tick();
        n_checks++; if (pc_out !== 16'hABCD) begin n_fail++; $display("FAIL prio_load got %h exp ABCD", pc_out); end
        load = 1'b0; set_pc(16'h1000);
        branch = 1'b1; inc = 1'b1; data_in = 8'h02; tick(); branch = 1'b0; inc = 1'b0;
        n_checks++; if (pc_out !== 16'h1002) begin n_fail++; $display("FAIL prio_branch got %h exp 1002", pc_out); end
    endtask

    task automatic test_reset_midflight();
        set_pc(16'h10F0);
        branch = 1'b1; data_in = 8'h20; tick(); branch = 1'b0;
        reset_n = 1'b0; inc = 1'b1; tick(); inc = 1'b0;
        n_checks++; if ({pc_out, vec_addr, vec_req, ready, page_cross} !== {16'h0000, 16'hFFFC, 3'b100}) begin
            n_fail++; $display("FAIL rst_brfix got pc %h addr %h flags %b exp 0000 FFFC 100", pc_out, vec_addr, {vec_req, ready, page_cross});
        end
        reset_n = 1'b1; tick();
        n_checks++; if ({page_cross, vec_req, pc_out} !== {2'b01, 16'h0000}) begin
            n_fail++; $display("FAIL rst_brfix_after got pcx %b req %b pc %h exp 0 1 0000", page_cross, vec_req, pc_out);
        end
        data_valid = 1'b1; data_in = 8'hAA; tick();
        reset_n = 1'b0; tick(); reset_n = 1'b1; data_valid = 1'b0;
        n_checks++; if ({vec_addr, pc_out} !== {16'hFFFC, 16'h0000}) begin
            n_fail++; $display("FAIL rst_vec_hi got addr %h pc %h exp FFFC 0000", vec_addr, pc_out);
        end
    endtask

`ifdef PC_WATCH_EN
    task automatic test_watch();
        watch_addr = 16'h0000;
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick(); tick();
        n_checks++; if (watch_hit !== 1'b0) begin n_fail++; $display("FAIL watch_vec got %b exp 0", watch_hit); end
        boot(8'h00, 8'h00);
        watch_addr = 16'h1235;
        set_pc(16'h1234);
        inc = 1'b1; tick();
        n_checks++; if (watch_hit !== 1'b0) begin n_fail++; $display("FAIL watch_pre got %b exp 0", watch_hit); end
        tick(); inc = 1'b0;
        n_checks++; if (watch_hit !== 1'b1) begin n_fail++; $display("FAIL watch_hit got %b exp 1", watch_hit); end
        tick();
        n_checks++; if (watch_hit !== 1'b0) begin n_fail++; $display("FAIL watch_post got %b exp 0", watch_hit); end
    endtask
`endif

    initial begin
        reset_n = 1'b0; data_in = 8'h00; data_valid = 1'b0; addr_in = 16'h0000;
        inc = 1'b0; load = 1'b0; branch = 1'b0;
`ifdef PC_WATCH_EN
        watch_addr = 16'h0000;
`endif
        #1;
        test_reset();
        test_vector_stall();
        test_branch_same_page();
        test_page_cross();
        test_inc_priority();
        test_reset_midflight();
`ifdef PC_WATCH_EN
        test_watch();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
